// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA
// scan-out (absolute priority while active) and a small CPU write FIFO that
// drains during blanking. Display reads have 1-cycle RAM latency and are
// re-timed to a 2-cycle pixel stream.
// Optional feature: define ARB_STALL_CNT_EN to add the 16-bit stall_cnt
// output counting refused CPU requests per frame.
module vga_fb_arbiter #(
  parameter int unsigned WIDTH  = 800,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk25,
  input  logic        resetn,
  input  logic        active,
  input  logic        screenEnd,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        cpu_req,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        cpu_ack,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        oob_err
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_LEN  = ADDR_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  fifo_entry_t      r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Display delay pipeline
  logic r_act_d1;
  logic r_act_d2;
  logic [DATA_W-1:0] r_pix_data;

  state_e            w_state;
  logic              w_full;
  logic              w_empty;
  logic              w_oob;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_disp_addr;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_oob       = (cpu_addr >= PIX_TOTAL);
  assign w_disp_addr = (ADDR_W'(y) * LINE_LEN) + ADDR_W'(x);

  // CPU handshake: full is judged on the registered level, before any pop
  assign cpu_ack = resetn & cpu_req & ~w_full;
  assign oob_err = cpu_ack & w_oob;
  assign w_push  = cpu_ack & ~w_oob;

  // Mode is decoded from live inputs every cycle so display never loses a slot
  always_comb begin
    w_state = ST_IDLE;
    if (!resetn) begin
      w_state = ST_IDLE;
    end else if (active) begin
      w_state = ST_DISP;
    end else if (!w_empty) begin
      w_state = ST_WR;
    end
  end

  // RAM port drive and FIFO pop per mode
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_pop     = 1'b0;
    unique case (w_state)
      ST_DISP: begin
        mem_addr = w_disp_addr;
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = r_fifo[r_rd_ptr].addr;
        mem_wdata = r_fifo[r_rd_ptr].data;
        w_pop     = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // FIFO payload write; storage needs no reset since count gates reads
  always_ff @(posedge clk25) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{addr: cpu_addr, data: cpu_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Align pixel data with the 1-cycle RAM read and emit a 2-cycle valid
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_act_d1   <= 1'b0;
      r_act_d2   <= 1'b0;
      r_pix_data <= '0;
    end else begin
      r_act_d1   <= active;
      r_act_d2   <= r_act_d1;
      r_pix_data <= r_act_d1 ? mem_rdata : '0;
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_act_d2;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Refused-request counter, saturating, cleared once per frame
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (screenEnd) begin
      r_stall_cnt <= '0;
    end else if (cpu_req && !cpu_ack && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_screen_end;
  assign w_unused_screen_end = screenEnd;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: display path timing, FIFO stall/drain
// order, full refusal, out-of-range drop, async reset. Stall counter checks
// run only when ARB_STALL_CNT_EN is defined.
module tb_vga_fb_arbiter;

  logic        clk25;
  logic        resetn;
  logic        active;
  logic        screenEnd;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        cpu_req;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ack;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        oob_err;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vga_fb_arbiter #(.WIDTH(800), .HEIGHT(480), .DEPTH(4)) dut (
    .clk25     (clk25),
    .resetn    (resetn),
    .active    (active),
    .screenEnd (screenEnd),
    .x         (x),
    .y         (y),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ack   (cpu_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .oob_err   (oob_err)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    active    = 1'b0;
    screenEnd = 1'b0;
    x         = '0;
    y         = '0;
    cpu_req   = 1'b1;
    cpu_addr  = 19'd50;
    cpu_data  = 8'h00;
    mem_rdata = 8'h00;

    // Reset state
    #30;
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_oob", 32'(oob_err), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    cpu_req = 1'b0;
    step();
    resetn = 1'b1;

    // Display read: address, then pixel two cycles after active
    step();
    active = 1'b1; x = 10'd5; y = 9'd2;
    #1;
    check("disp_addr", 32'(mem_addr), 32'd1605);
    check("disp_we", 32'(mem_we), 32'd0);
    step();
    active = 1'b0; mem_rdata = 8'hA5;
    #1;
    check("disp_valid_early", 32'(pix_valid), 32'd0);
    step();
    mem_rdata = 8'h00;
    #1;
    check("disp_pix_data", 32'(pix_data), 32'hA5);
    check("disp_pix_valid", 32'(pix_valid), 32'd1);
    step();
    #1;
    check("disp_valid_off", 32'(pix_valid), 32'd0);
    check("disp_data_off", 32'(pix_data), 32'd0);

    // Five requests during active: four accepted, held until blanking
    active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      cpu_req = 1'b1; cpu_addr = 19'(100 + i); cpu_data = 8'(8'h10 + i);
      #1;
      check($sformatf("stall_ack%0d", i), 32'(cpu_ack), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("stall_we%0d", i), 32'(mem_we), 32'd0);
    end
    step();
    cpu_req = 1'b0;
    #1;
    check("stall_hold_we", 32'(mem_we), 32'd0);
    step();
    active = 1'b0;
    #1;
    check("drain_we0", 32'(mem_we), 32'd1);
    check("drain_addr0", 32'(mem_addr), 32'd100);
    check("drain_data0", 32'(mem_wdata), 32'h10);
    for (int i = 1; i < 4; i++) begin
      step();
      #1;
      check($sformatf("drain_we%0d", i), 32'(mem_we), 32'd1);
      check($sformatf("drain_addr%0d", i), 32'(mem_addr), 32'(100 + i));
      check($sformatf("drain_data%0d", i), 32'(mem_wdata), 32'(8'h10 + i));
    end
    step();
    #1;
    check("drain_done_we", 32'(mem_we), 32'd0);
    check("idle_addr", 32'(mem_addr), 32'd0);

    // Full FIFO while blanking: pop this cycle, refuse, accept next cycle
    active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      cpu_req = 1'b1; cpu_addr = 19'(200 + i); cpu_data = 8'(8'h20 + i);
      #1;
      check($sformatf("fill_ack%0d", i), 32'(cpu_ack), 32'd1);
    end
    step();
    active = 1'b0; cpu_addr = 19'd300; cpu_data = 8'h55;
    #1;
    check("full_ack", 32'(cpu_ack), 32'd0);
    check("full_pop_we", 32'(mem_we), 32'd1);
    check("full_pop_addr", 32'(mem_addr), 32'd200);
    step();
    #1;
    check("full_next_ack", 32'(cpu_ack), 32'd1);
    check("full_next_addr", 32'(mem_addr), 32'd201);
    step();
    cpu_req = 1'b0;
    #1;
    check("full_addr2", 32'(mem_addr), 32'd202);
    step();
    #1;
    check("full_addr3", 32'(mem_addr), 32'd203);
    step();
    #1;
    check("full_addr4", 32'(mem_addr), 32'd300);
    check("full_data4", 32'(mem_wdata), 32'h55);
    check("full_we4", 32'(mem_we), 32'd1);
    step();
    #1;
    check("full_done_we", 32'(mem_we), 32'd0);

    // Out-of-range write dropped; last legal address accepted
    cpu_req = 1'b1; cpu_addr = 19'd384000; cpu_data = 8'h77;
    #1;
    check("oob_ack", 32'(cpu_ack), 32'd1);
    check("oob_err", 32'(oob_err), 32'd1);
    check("oob_no_bypass_we", 32'(mem_we), 32'd0);
    step();
    cpu_addr = 19'd383999; cpu_data = 8'h66;
    #1;
    check("oob_pulse_end", 32'(oob_err), 32'd0);
    check("oob_never_we", 32'(mem_we), 32'd0);
    check("edge_ack", 32'(cpu_ack), 32'd1);
    step();
    cpu_req = 1'b0;
    #1;
    check("edge_we", 32'(mem_we), 32'd1);
    check("edge_addr", 32'(mem_addr), 32'd383999);
    check("edge_data", 32'(mem_wdata), 32'h66);
    step();
    #1;
    check("edge_done_we", 32'(mem_we), 32'd0);

    // Drain interrupted by active: stall, then resume in order
    active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      cpu_req = 1'b1; cpu_addr = 19'(40 + i); cpu_data = 8'(8'h40 + i);
      #1;
    end
    step();
    cpu_req = 1'b0; active = 1'b0;
    #1;
    check("intr_addr0", 32'(mem_addr), 32'd40);
    check("intr_we0", 32'(mem_we), 32'd1);
    step();
    active = 1'b1;
    #1;
    check("intr_stall_we", 32'(mem_we), 32'd0);
    step();
    active = 1'b0;
    #1;
    check("intr_addr1", 32'(mem_addr), 32'd41);
    check("intr_we1", 32'(mem_we), 32'd1);
    step();
    #1;
    check("intr_done_we", 32'(mem_we), 32'd0);

    // Async reset with three writes queued
    active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      cpu_req = 1'b1; cpu_addr = 19'(10 + i); cpu_data = 8'(8'h30 + i);
      #1;
    end
    step();
    cpu_req = 1'b0;
    step();
    #1;
    check("prerst_valid", 32'(pix_valid), 32'd1);
    #5;
    active = 1'b0; resetn = 1'b0; cpu_req = 1'b1; cpu_addr = 19'd20;
    #1;
    check("arst_valid", 32'(pix_valid), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_ack", 32'(cpu_ack), 32'd0);
    step();
    step();
    cpu_req = 1'b0; resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("postrst_we%0d", i), 32'(mem_we), 32'd0);
      step();
    end

`ifdef ARB_STALL_CNT_EN
    // Ten refused cycles counted, cleared after screenEnd
    active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      cpu_req = 1'b1; cpu_addr = 19'(500 + i); cpu_data = 8'h01;
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
    end
    step();
    cpu_req = 1'b0; screenEnd = 1'b1;
    #1;
    check("stall_cnt10", 32'(stall_cnt), 32'd10);
    step();
    screenEnd = 1'b0;
    #1;
    check("stall_cnt_clr", 32'(stall_cnt), 32'd0);
    active = 1'b0;
    for (int i = 0; i < 5; i++) step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 800, visible pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, visible lines per frame.
REQ-003 SHALL have parameter DEPTH, default 4 (power of two, 2..16), CPU write FIFO entries.
REQ-004 SHALL have port clk25  in  1  25 MHz pixel clock, the single clock; all state on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports active, screenEnd  in  1 each  from timing generator: visible area; last cycle of frame.
REQ-007 SHALL have ports x  in  10, y  in  9  pixel coordinates from timing generator.
REQ-008 SHALL have ports cpu_req  in  1, cpu_addr  in  19, cpu_data  in  8  CPU pixel-write request.
REQ-009 SHALL have port cpu_ack  out  1  request accepted this cycle.
REQ-010 SHALL have ports mem_addr  out  19, mem_wdata  out  8, mem_we  out  1, mem_rdata  in  8  single-port framebuffer RAM, 1-cycle read latency.
REQ-011 SHALL have ports pix_data  out  8, pix_valid  out  1  pixel stream to DAC.
REQ-012 SHALL have port oob_err  out  1  one-cycle pulse on an accepted out-of-range write.

Function
REQ-013 SHALL use states DISP (active=1), WR (active=0, FIFO non-empty), IDLE (active=0, FIFO empty), re-evaluated every cycle from current active and FIFO level.
REQ-014 In DISP: mem_addr = y*WIDTH + x (19-bit, combinational), mem_we=0; display has absolute priority, no FIFO pop.
REQ-015 In WR: mem_addr/mem_wdata = FIFO head, mem_we=1, head popped at that clock edge; one entry per cycle.
REQ-016 In IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 pix_valid SHALL equal active delayed 2 cycles; pix_data SHALL be mem_rdata registered when the delayed-by-1 active is 1, else 0.
REQ-018 cpu_ack SHALL be combinational: cpu_req=1 and FIFO not full; accepted entry pushed at that edge.
REQ-019 Full evaluated before same-cycle pop: push into a full FIFO SHALL be refused (cpu_ack=0) even if a pop occurs that cycle.
REQ-020 No bypass: an entry pushed into an empty FIFO SHALL reach the RAM no earlier than the next cycle.
REQ-021 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged.
REQ-022 cpu_addr >= WIDTH*HEIGHT SHALL be acked, not pushed, and oob_err pulsed that cycle.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 A write pending when active rises SHALL stall until active falls; order preserved.

Reset
REQ-025 resetn=0 SHALL immediately clear FIFO (pending writes discarded), state to IDLE, pix_data=0, pix_valid=0, oob_err=0, delay pipeline=0; cpu_ack=0 while resetn=0.
REQ-026 Reset mid-frame SHALL not require re-alignment; operation resumes from current active/x/y on first edge after release.

Configuration
REQ-027 With ARB_STALL_CNT_EN defined: output stall_cnt (16 bits) SHALL count cycles with cpu_req=1 and cpu_ack=0, saturating at 65535, cleared to 0 in the cycle after screenEnd=1 and by reset.
REQ-028 Without ARB_STALL_CNT_EN: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 active=1, x=5, y=2 -> mem_addr=1605, mem_we=0; mem_rdata=0xA5 next cycle -> pix_data=0xA5, pix_valid=1 two cycles after active.
REQ-030 active=1, 5 back-to-back cpu_req (DEPTH=4) -> first 4 acked, 5th cpu_ack=0, no mem_we until active falls, then 4 writes in push order on consecutive cycles.
REQ-031 FIFO full, active=0, cpu_req=1 -> pop occurs, cpu_ack=0 that cycle, cpu_ack=1 next cycle.
REQ-032 cpu_addr=384000 with cpu_req=1 -> cpu_ack=1, oob_err=1 one cycle, no RAM write ever issued.
REQ-033 3 entries queued, resetn pulsed low mid-blanking -> outputs cleared asynchronously, no further mem_we after release.
REQ-034 ARB_STALL_CNT_EN: 10 refused cycles then screenEnd=1 -> stall_cnt=10, then 0 the following cycle.
